// File: rtl/nios_fprint_processor0_0_cpu0_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: start/busy/done handshake with flush.
// Optional macro DIV_CELL_FAST_PATH_EN skips the iteration loop for zero divisors and |dividend| < |divisor|.
module nios_fprint_processor0_0_cpu0_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_div_start,
    input  logic [WIDTH-1:0] E_src1_div_cell,
    input  logic [WIDTH-1:0] E_src2_div_cell,
    input  logic             E_ctrl_div_signed,
    input  logic             E_ctrl_div_rem,
    input  logic             div_abort,
    output logic             div_busy,
    output logic             A_div_cell_done,
    output logic [WIDTH-1:0] A_div_cell_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ITER, S_FIXUP} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] src1_reg, src2_reg;
    logic             signed_reg, rem_reg, neg_q_reg, neg_r_reg;
    // The remainder always stays below the divisor, so WIDTH bits hold it;
    // the shifted value below carries the extra (WIDTH+1)th bit.
    logic [WIDTH-1:0] r_reg, q_reg, d_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             done_reg;

    logic [WIDTH-1:0] mag1, mag2, q_fix, r_fix;
    logic             div_zero, fast_take, trial_ok;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        mag1     = (signed_reg && src1_reg[WIDTH-1]) ? -src1_reg : src1_reg;
        mag2     = (signed_reg && src2_reg[WIDTH-1]) ? -src2_reg : src2_reg;
        div_zero = (src2_reg == '0);
`ifdef DIV_CELL_FAST_PATH_EN
        fast_take = div_zero || (mag1 < mag2);
`else
        fast_take = 1'b0;
`endif
        r_shift  = {r_reg, q_reg[WIDTH-1]};
        trial    = {1'b0, r_shift} - {2'b00, d_reg};
        trial_ok = ~trial[WIDTH+1];
        q_fix    = neg_q_reg ? -q_reg : q_reg;
        r_fix    = neg_r_reg ? -r_reg : r_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (E_div_start && !div_abort) state_next = S_SETUP;
            S_SETUP: state_next = div_abort ? S_IDLE : (fast_take ? S_FIXUP : S_ITER);
            S_ITER:  if (div_abort) state_next = S_IDLE;
                     else if (cnt_reg == '0) state_next = S_FIXUP;
            S_FIXUP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src1_reg   <= '0;
            src2_reg   <= '0;
            signed_reg <= 1'b0;
            rem_reg    <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            r_reg      <= '0;
            q_reg      <= '0;
            d_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (E_div_start && !div_abort) begin
                        src1_reg   <= E_src1_div_cell;
                        src2_reg   <= E_src2_div_cell;
                        signed_reg <= E_ctrl_div_signed;
                        rem_reg    <= E_ctrl_div_rem;
                    end
                end
                S_SETUP: begin
                    // A zero divisor yields an all-ones quotient regardless of operand signs.
                    neg_q_reg <= signed_reg & (src1_reg[WIDTH-1] ^ src2_reg[WIDTH-1]) & ~div_zero;
                    neg_r_reg <= signed_reg & src1_reg[WIDTH-1];
                    d_reg     <= mag2;
                    cnt_reg   <= CW'(WIDTH - 1);
                    if (fast_take) begin
                        r_reg <= mag1;
                        q_reg <= div_zero ? '1 : '0;
                    end else begin
                        r_reg <= '0;
                        q_reg <= mag1;
                    end
                end
                S_ITER: begin
                    r_reg   <= trial_ok ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
                    q_reg   <= {q_reg[WIDTH-2:0], trial_ok};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                S_FIXUP: begin
                    if (!div_abort) begin
                        result_reg <= rem_reg ? r_fix : q_fix;
                        done_reg   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_busy          = (state_reg != S_IDLE);
    assign A_div_cell_done   = done_reg;
    assign A_div_cell_result = result_reg;

endmodule

// File: tb/tb_nios_fprint_processor0_0_cpu0_div_cell.sv
// Directed bench for the iterative divider: results, latency, busy window, abort, restart and reset.
module tb_nios_fprint_processor0_0_cpu0_div_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_div_start;
    logic [31:0] E_src1_div_cell, E_src2_div_cell;
    logic        E_ctrl_div_signed, E_ctrl_div_rem;
    logic        div_abort;
    logic        div_busy, A_div_cell_done;
    logic [31:0] A_div_cell_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_fprint_processor0_0_cpu0_div_cell #(.WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .E_div_start       (E_div_start),
        .E_src1_div_cell   (E_src1_div_cell),
        .E_src2_div_cell   (E_src2_div_cell),
        .E_ctrl_div_signed (E_ctrl_div_signed),
        .E_ctrl_div_rem    (E_ctrl_div_rem),
        .div_abort         (div_abort),
        .div_busy          (div_busy),
        .A_div_cell_done   (A_div_cell_done),
        .A_div_cell_result (A_div_cell_result)
    );

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_CELL_FAST_PATH_EN
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (b == 32'd0 || ma < mb) return 3;
`endif
        return 35;
    endfunction

    task automatic issue(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        E_src1_div_cell   = a;
        E_src2_div_cell   = b;
        E_ctrl_div_signed = sgn;
        E_ctrl_div_rem    = rem;
        E_div_start       = 1'b1;
        @(posedge clk);
        #1 E_div_start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic rem,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        int cyc, busy_cnt, lat;
        bit seen;
        lat = exp_latency(sgn, a, b);
        issue(sgn, rem, a, b);
        cyc = 0; busy_cnt = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (div_busy) busy_cnt++;
            if (A_div_cell_done) seen = 1;
        end
        check_value({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_value({tag, "_result"}, A_div_cell_result, exp_res);
        check_value({tag, "_latency"}, 32'(cyc), 32'(lat));
        check_value({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        @(negedge clk);
        check_value({tag, "_done_pulse_end"}, 32'(A_div_cell_done), 32'd0);
    endtask

    initial begin
        int cyc, dones;
        reset = 1'b1; E_div_start = 1'b0; div_abort = 1'b0;
        E_src1_div_cell = '0; E_src2_div_cell = '0;
        E_ctrl_div_signed = 1'b0; E_ctrl_div_rem = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_value("reset_busy", 32'(div_busy), 32'd0);
        check_value("reset_done", 32'(A_div_cell_done), 32'd0);
        check_value("reset_result", A_div_cell_result, 32'd0);

        run_op("u_100_7_q", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        run_op("u_100_7_r", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
        run_op("s_m7_2_q",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("s_m7_2_r",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("s_7_m2_q",  1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("s_7_m2_r",  1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("s_m5_0_q",  1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op("s_m5_0_r",  1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op("u_5_0_q",   1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("s_ovf_q",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("s_ovf_r",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("u_max_16_q", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
        run_op("u_max_16_r", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16, 32'd15);
        run_op("u_3_10_q",  1'b0, 1'b0, 32'd3, 32'd10, 32'd0);
        run_op("u_3_10_r",  1'b0, 1'b1, 32'd3, 32'd10, 32'd3);

        // Abort in the tenth iteration cycle leaves the previous result intact.
        run_op("pre_abort", 1'b0, 1'b0, 32'h1234, 32'd1, 32'h1234);
        issue(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        div_abort = 1'b1;
        @(posedge clk);
        #1 div_abort = 1'b0;
        @(negedge clk);
        check_value("abort_busy", 32'(div_busy), 32'd0);
        check_value("abort_done", 32'(A_div_cell_done), 32'd0);
        check_value("abort_result", A_div_cell_result, 32'h1234);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (A_div_cell_done) dones++;
        end
        check_value("abort_no_done", 32'(dones), 32'd0);
        run_op("post_abort", 1'b0, 1'b0, 32'd1000, 32'd3, 32'd333);

        // Abort in IDLE blocks a simultaneous start.
        @(negedge clk);
        E_div_start = 1'b1; div_abort = 1'b1;
        @(posedge clk);
        #1 begin E_div_start = 1'b0; div_abort = 1'b0; end
        @(negedge clk);
        check_value("idle_abort_blocks_start", 32'(div_busy), 32'd0);

        // A second start while busy is ignored.
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        cyc = 0;
        while (!A_div_cell_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                E_src1_div_cell = 32'd50; E_src2_div_cell = 32'd5;
                E_ctrl_div_rem = 1'b1; E_div_start = 1'b1;
            end
            if (cyc == 6) E_div_start = 1'b0;
        end
        check_value("busy_start_result", A_div_cell_result, 32'd14);
        check_value("busy_start_latency", 32'(cyc), 32'd35);
        @(negedge clk);
        check_value("busy_start_idle_after", 32'(div_busy), 32'd0);

        // Reset in the middle of the iteration loop.
        issue(1'b0, 1'b0, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_value("midreset_busy", 32'(div_busy), 32'd0);
        check_value("midreset_done", 32'(A_div_cell_done), 32'd0);
        check_value("midreset_result", A_div_cell_result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
